// File: rtl/debugger_tx_serializer.sv
// Debug-frame serializer: snapshots a wide vector on request and streams it
// LSB-first, one byte every other cycle, into the UART transmit FIFO.
module debugger_tx_serializer #(
  parameter int NUM_BYTES = 220,
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sendSignal,
  input  logic [NUM_BYTES*8-1:0] sendData,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   dataSent,
  output logic                   busy
);

  localparam int W = NUM_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shift_q, shift_d;
  logic             wr_d, sent_d, busy_d;
  logic [7:0]       byte_d;
  logic             last;

  assign last = (cnt_q == CNT_W'(NUM_BYTES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      wr_uart  <= 1'b0;
      w_data   <= 8'h00;
      dataSent <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      wr_uart  <= wr_d;
      w_data   <= byte_d;
      dataSent <= sent_d;
      busy     <= busy_d;
    end
  end

  // GAP gives tx_full one cycle to reflect the previous write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    wr_d    = 1'b0;
    byte_d  = w_data;
    sent_d  = dataSent;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        sent_d = 1'b0;
        if (sendSignal) begin
          shift_d = sendData;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          byte_d  = shift_q[7:0];
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (last) begin
          sent_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        if (!sendSignal) begin
          sent_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
